// File: rtl/dmem_mmio_bus.sv
// Data RAM plus MMIO bank (byte TX FIFO, cycle counter, scratch) sitting behind the M stage.
// Loads are combinational from the current address; stores commit on the rising edge.
module dmem_mmio_bus #(
  parameter int          RAM_WORDS     = 256,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [3:0]  MMIO_BASE_NIB = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  logic                is_mmio;
  logic                is_ram;
  logic [1:0]          mmio_off;
  logic [RAM_AW-1:0]   ram_idx;
  logic                unused_addr;

  logic [31:0]         ram [RAM_WORDS];

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                ovf;
  logic                full;
  logic                empty;

  logic [31:0]         cycle_cnt;
  logic [31:0]         scratch;
  logic [31:0]         status;
  logic [31:0]         rdata;

  logic                wr_txdata;
  logic                wr_status;
  logic                wr_cycle;
  logic                wr_scratch;
  logic                push;
  logic                pop;

  // MMIO wins if the base nibble is ever configured to overlap RAM space.
  assign is_mmio     = (ALUResultM[31:28] == MMIO_BASE_NIB);
  assign is_ram      = !is_mmio && (ALUResultM[31:28] == 4'h0) &&
                       ({6'd0, ALUResultM[27:2]} < 32'(RAM_WORDS));
  assign mmio_off    = ALUResultM[3:2];
  assign ram_idx     = ALUResultM[2 +: RAM_AW];
  assign unused_addr = ^ALUResultM[1:0];

  assign wr_txdata  = MemWriteM && is_mmio && (mmio_off == OFF_TXDATA);
  assign wr_status  = MemWriteM && is_mmio && (mmio_off == OFF_STATUS);
  assign wr_cycle   = MemWriteM && is_mmio && (mmio_off == OFF_CYCLE);
  assign wr_scratch = MemWriteM && is_mmio && (mmio_off == OFF_SCRATCH);

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == CNT_W'(0));
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // Admission uses start-of-cycle fullness, so a same-cycle pop never rescues a push.
  assign push = wr_txdata && !full;
  assign pop  = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (MemWriteM && is_ram) begin
      ram[ram_idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= WriteDataM[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= FIFO_AW'(0);
      wr_ptr <= FIFO_AW'(0);
      count  <= CNT_W'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push sets ovf even if software clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_txdata && full) begin
      ovf <= 1'b1;
    end else if (wr_status && WriteDataM[2]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0000_0000;
      scratch   <= 32'h0000_0000;
    end else begin
      if (wr_cycle) begin
        cycle_cnt <= WriteDataM;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (wr_scratch) begin
        scratch <= WriteDataM;
      end
    end
  end

  always_comb begin
    status       = 32'h0000_0000;
    status[15:8] = 8'(count);
    status[2]    = ovf;
    status[1]    = empty;
    status[0]    = full;
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (is_mmio) begin
      case (mmio_off)
        OFF_TXDATA:  rdata = 32'h0000_0000;
        OFF_STATUS:  rdata = status;
        OFF_CYCLE:   rdata = cycle_cnt;
        OFF_SCRATCH: rdata = scratch;
        default:     rdata = 32'h0000_0000;
      endcase
    end else if (is_ram) begin
      rdata = ram[ram_idx];
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign ReadDataM = rdata;

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Self-checking bench for dmem_mmio_bus: directed scenarios plus randomized traffic
// checked every cycle against a queue/array reference model.
module tb_dmem_mmio_bus;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_CYC  = 32'h1000_0008;
  localparam logic [31:0] A_SCR  = 32'h1000_000C;
  localparam logic [31:0] A_IDLE = 32'h2000_0000;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks;
  int failures;

  // reference model state
  logic [7:0]  mq[$];
  logic [31:0] m_ram [256];
  logic        m_ovf;
  logic [31:0] m_cycle;
  logic [31:0] m_scratch;
  bit          model_ok;

  dmem_mmio_bus dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[31:28] == 4'h1) begin
      case (a[3:2])
        2'd1: r = {16'h0, 8'(mq.size()), 5'd0, m_ovf, mq.size() == 0, mq.size() == 4};
        2'd2: r = m_cycle;
        2'd3: r = m_scratch;
        default: r = 32'h0;
      endcase
    end else if (a[31:28] == 4'h0 && a[27:2] < 26'd256) begin
      r = m_ram[a[9:2]];
    end
    return r;
  endfunction

  function automatic void model_update();
    bit mmio, ram_hit, was_full, push_req;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cycle = 32'h0;
      m_scratch = 32'h0;
      model_ok = 1'b1;
      return;
    end
    mmio     = (ALUResultM[31:28] == 4'h1);
    ram_hit  = (ALUResultM[31:28] == 4'h0) && (ALUResultM[27:2] < 26'd256);
    was_full = (mq.size() == 4);
    push_req = MemWriteM && mmio && ALUResultM[3:2] == 2'd0;
    if (tx_ready && mq.size() > 0) void'(mq.pop_front());
    if (push_req) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(WriteDataM[7:0]);
    end else if (MemWriteM && mmio && ALUResultM[3:2] == 2'd1 && WriteDataM[2]) begin
      m_ovf = 1'b0;
    end
    if (MemWriteM && mmio && ALUResultM[3:2] == 2'd2) m_cycle = WriteDataM;
    else m_cycle = m_cycle + 32'd1;
    if (MemWriteM && mmio && ALUResultM[3:2] == 2'd3) m_scratch = WriteDataM;
    if (MemWriteM && ram_hit) m_ram[ALUResultM[9:2]] = WriteDataM;
  endfunction

  task automatic apply(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    reset = r; MemWriteM = w; ALUResultM = a; WriteDataM = d; tx_ready = rdy;
    #1;
    if (model_ok) begin
      check_eq("rdata", ReadDataM, model_read(a));
      check_eq("tx_valid", {31'd0, tx_valid}, {31'd0, mq.size() != 0});
      if (mq.size() > 0) check_eq("tx_data", {24'd0, tx_data}, {24'd0, mq[0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    apply(r, w, a, d, rdy);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    checks = 0; failures = 0; model_ok = 1'b0;
    reset = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0; tx_ready = 1'b0;

    step(1'b1, 1'b0, A_IDLE, 32'h0, 1'b0);
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("reset_status", ReadDataM, 32'h0000_0002);
    check_eq("reset_valid", {31'd0, tx_valid}, 32'd0);
    tick();

    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);

    // RAM directed
    step(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
    apply(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    check_eq("ram_rd_during_wr", ReadDataM, 32'h1111_1111);
    tick();
    apply(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check_eq("ram_load", ReadDataM, 32'hDEAD_BEEF);
    tick();
    step(1'b0, 1'b1, 32'h0000_0014, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
    check_eq("ram_zero", ReadDataM, 32'h0);
    tick();
    apply(1'b0, 1'b0, 32'h2000_0000, 32'h0, 1'b0);
    check_eq("unmapped", ReadDataM, 32'h0);
    tick();

    // FIFO fill with sink stalled
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, A_TX, 32'h41 + 32'(i), 1'b0);
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("fill_status", ReadDataM, 32'h0000_0405);
    check_eq("fill_head", {24'd0, tx_data}, 32'h41);
    tick();
    step(1'b0, 1'b1, A_ST, 32'h4, 1'b0);
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("ovf_clear", ReadDataM, 32'h0000_0401);
    tick();

    // Drain
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, A_ST, 32'h0, 1'b1);
      check_eq("drain_byte", {24'd0, tx_data}, 32'h41 + 32'(i));
      tick();
    end
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b1);
    check_eq("drain_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("drain_status", ReadDataM, 32'h0000_0002);
    tick();

    // Simultaneous push and pop
    step(1'b0, 1'b1, A_TX, 32'h51, 1'b0);
    step(1'b0, 1'b1, A_TX, 32'h52, 1'b0);
    step(1'b0, 1'b1, A_TX, 32'h55, 1'b1);
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("simul_status", ReadDataM, 32'h0000_0200);
    tick();
    apply(1'b0, 1'b0, A_IDLE, 32'h0, 1'b1);
    check_eq("simul_b0", {24'd0, tx_data}, 32'h52);
    tick();
    apply(1'b0, 1'b0, A_IDLE, 32'h0, 1'b1);
    check_eq("simul_b1", {24'd0, tx_data}, 32'h55);
    tick();

    // Cycle counter
    step(1'b1, 1'b0, A_IDLE, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, A_IDLE, 32'h0, 1'b0);
    apply(1'b0, 1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycle_10", ReadDataM, 32'd10);
    tick();
    step(1'b0, 1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, 1'b0, A_IDLE, 32'h0, 1'b0);
    apply(1'b0, 1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycle_max", ReadDataM, 32'hFFFF_FFFF);
    tick();
    apply(1'b0, 1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycle_wrap", ReadDataM, 32'h0);
    tick();

    // Full FIFO with same-cycle pop: push dropped
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, A_TX, 32'h61 + 32'(i), 1'b0);
    step(1'b0, 1'b1, A_TX, 32'h66, 1'b1);
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("full_drop", ReadDataM, 32'h0000_0304);
    check_eq("full_head", {24'd0, tx_data}, 32'h62);
    tick();

    // Reset mid-operation
    step(1'b0, 1'b1, A_SCR, 32'h0000_1234, 1'b0);
    apply(1'b0, 1'b0, A_SCR, 32'h0, 1'b0);
    check_eq("scratch_rw", ReadDataM, 32'h0000_1234);
    tick();
    step(1'b1, 1'b0, A_IDLE, 32'h0, 1'b1);
    apply(1'b0, 1'b0, A_CYC, 32'h0, 1'b1);
    check_eq("rst_cycle", ReadDataM, 32'h0);
    check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    apply(1'b0, 1'b0, A_ST, 32'h0, 1'b0);
    check_eq("rst_status", ReadDataM, 32'h0000_0002);
    tick();
    apply(1'b0, 1'b0, A_SCR, 32'h0, 1'b0);
    check_eq("rst_scratch", ReadDataM, 32'h0);
    tick();
    apply(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check_eq("rst_ram_kept", ReadDataM, 32'hDEAD_BEEF);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = {22'd0, 8'($urandom), 2'($urandom)};
      else if (sel < 8)  a = {4'h1, 24'($urandom), 2'($urandom), 2'($urandom)};
      else if (sel == 8) a = {4'($urandom_range(2, 15)), 28'($urandom)};
      else               a = {4'h0, 26'($urandom_range(256, 32'h03FF_FFFF)), 2'($urandom)};
      if ($urandom_range(0, 63) == 0) step(1'b1, 1'b0, a, $urandom, 1'($urandom));
      else step(1'b0, 1'($urandom), a, $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_bus.md
Name: dmem_mmio_bus

Overview:
- Data-memory and memory-mapped I/O slave directly downstream of the pipelined core's Memory stage.
- Consumes the M-stage address, write data and write strobe; returns load data in the same cycle.
- Decodes each access to a word-addressed data RAM or to a small MMIO register bank.
- The MMIO bank holds a byte transmit FIFO with a valid/ready output, a free-running cycle counter and a scratch register.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of 2, at least 2.
- MMIO_BASE_NIB, 4'h1, value of addr[31:28] that selects MMIO space.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWriteM  in  1  store strobe from M stage.
- ALUResultM  in  32  byte address from M stage; only word-aligned accesses are supported, and addr[1:0] is ignored.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data, combinational from the current address.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts the head byte when tx_valid is also high.

Behaviour:
Decode:
- addr[31:28]==MMIO_BASE_NIB selects MMIO, using offset addr[3:2].
- Else, if addr[31:28]==0 and addr[27:2] < RAM_WORDS, it is a RAM access at word index addr[2+:log2(RAM_WORDS)].
- All other addresses are unmapped: reads return 0, writes are ignored.

RAM:
- Writes are synchronous on MemWriteM.
- Reads are combinational (asynchronous array read).
- A read in the same cycle as a write to the same word returns the old data.
- Contents are not cleared by reset.

MMIO offsets:
- 0x0 TXDATA
  - Write pushes WriteDataM[7:0] if the FIFO is not full.
  - Write while full drops the byte and sets sticky ovf.
  - Read returns 0.
- 0x4 STATUS
  - Read returns {count in bits[15:8], 5'b0, ovf, empty, full}.
  - Write with WriteDataM[2]=1 clears ovf; all other bits are read-only.
- 0x8 CYCLE
  - 32-bit counter, increments every cycle and wraps 0xFFFFFFFF->0.
  - A write loads WriteDataM that cycle instead of incrementing.
  - A read returns the current value.
- 0xC SCRATCH
  - Plain 32-bit read/write register.

FIFO:
- Circular buffer with rd_ptr, wr_ptr and count (width log2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
- tx_valid = (count != 0); tx_data = mem[rd_ptr]. Both are registered-state outputs with no combinational path from tx_ready.
- Pop when tx_valid && tx_ready.
- Push admission is judged on full at the start of the cycle: a push while full is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- A push to an empty FIFO gives tx_valid=1 on the next cycle, not the same cycle.
- Setting ovf on a dropped push has priority over a same-cycle clear of ovf via STATUS.

Reset (synchronous):
- rd_ptr=wr_ptr=count=0, ovf=0, CYCLE=0, SCRATCH=0.
- Hence tx_valid=0 and STATUS reads 0x00000002.
- The FIFO data array and RAM are not reset.
- Reset asserted mid-transfer discards FIFO contents; no byte is presented after reset until a new push.

Timing:
- Stores take effect at the end of the M-stage cycle.
- Loads have zero-cycle latency relative to ALUResultM.

Test Plan:
- RAM: store 0xDEADBEEF to 0x00000010, then load 0x00000010 next cycle -> ReadDataM=0xDEADBEEF. Load 0x00000014, never written after a prior write of 0x0 -> 0x00000000. Load 0x20000000 -> 0.
- FIFO fill, tx_ready=0: write TXDATA (0x10000000) with 0x41,0x42,0x43,0x44,0x45.
  - STATUS = 0x00000405 (count 4, ovf=1, full=1).
  - tx_valid=1, tx_data=0x41.
  - Write STATUS 0x4 -> STATUS = 0x00000401.
- Drain: raise tx_ready for 4 cycles -> tx_data sequence 0x41,0x42,0x43,0x44; tx_valid low on cycle 5; STATUS = 0x00000002.
- Simultaneous: with count=2 and tx_ready=1, push 0x55 -> count stays 2, 0x55 delivered after the two older bytes. With FIFO full and tx_ready=1, push 0x66 -> dropped, ovf=1, count becomes 3.
- Cycle counter: after reset, read CYCLE at cycle 10 -> 10. Write 0xFFFFFFFE, then read on the next two cycles -> 0xFFFFFFFF, then 0x00000000.
- Reset mid-operation: with count=3, ovf=1, SCRATCH=0x1234, assert reset for 1 cycle -> tx_valid=0, STATUS=0x00000002, SCRATCH=0, CYCLE=0, while RAM contents are retained.
